// File: rtl/byte_stripping.sv
// Two-lane byte stripper: alternates an incoming byte stream between lane 0 and
// lane 1, aligning every new burst to lane 0 and re-arming after an idle gap.
module byte_stripping #(
  parameter int DATA_WIDTH   = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_stripe_0,
  output logic [DATA_WIDTH-1:0] data_stripe_1,
  output logic                  valid_stripe_0,
  output logic                  valid_stripe_1,
  output logic                  active
);

  // A zero timeout disables the return to IDLE; the counter keeps a 1-bit floor.
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_IDLE = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;
  localparam logic          TIMEOUT_EN = (IDLE_TIMEOUT > 0);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_phase;
  logic                  w_phase_nxt;
  logic [CW-1:0]         r_idle_cnt;
  logic [CW-1:0]         w_idle_cnt_nxt;
  logic [CW-1:0]         w_idle_inc;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_d0_nxt;
  logic [DATA_WIDTH-1:0] w_d1_nxt;
  logic                  w_v0_nxt;
  logic                  w_v1_nxt;

  assign w_idle_inc = (r_idle_cnt == {CW{1'b1}}) ? r_idle_cnt : r_idle_cnt + 1'b1;
  assign w_timeout  = TIMEOUT_EN && !valid_in && (r_idle_cnt == LAST_IDLE);
  assign active     = (r_state == S_ACTIVE);

  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_idle_cnt_nxt = r_idle_cnt;
    w_d0_nxt       = data_stripe_0;
    w_d1_nxt       = data_stripe_1;
    w_v0_nxt       = valid_stripe_0;
    w_v1_nxt       = valid_stripe_1;
    case (r_state)
      S_IDLE: begin
        w_v0_nxt = 1'b0;
        w_v1_nxt = 1'b0;
        if (valid_in) begin
          w_d0_nxt       = data_in;
          w_v0_nxt       = 1'b1;
          w_phase_nxt    = 1'b1;
          w_idle_cnt_nxt = '0;
          w_state_nxt    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_timeout) begin
          w_state_nxt    = S_IDLE;
          w_phase_nxt    = 1'b0;
          w_v0_nxt       = 1'b0;
          w_v1_nxt       = 1'b0;
          w_idle_cnt_nxt = '0;
        end else begin
          // Phase advances every slot so short gaps never shift lane alignment.
          w_phase_nxt = ~r_phase;
          if (valid_in) begin
            w_idle_cnt_nxt = '0;
            if (r_phase) begin
              w_d1_nxt = data_in;
              w_v1_nxt = 1'b1;
            end else begin
              w_d0_nxt = data_in;
              w_v0_nxt = 1'b1;
            end
          end else begin
            w_idle_cnt_nxt = w_idle_inc;
            if (r_phase) w_v1_nxt = 1'b0;
            else         w_v0_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_phase        <= 1'b0;
      r_idle_cnt     <= '0;
      data_stripe_0  <= '0;
      data_stripe_1  <= '0;
      valid_stripe_0 <= 1'b0;
      valid_stripe_1 <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase        <= w_phase_nxt;
      r_idle_cnt     <= w_idle_cnt_nxt;
      data_stripe_0  <= w_d0_nxt;
      data_stripe_1  <= w_d1_nxt;
      valid_stripe_0 <= w_v0_nxt;
      valid_stripe_1 <= w_v1_nxt;
    end
  end

endmodule

// File: tb/tb_byte_stripping.sv
// Bench for byte_stripping: a timeout=4 and a timeout=0 instance share stimulus;
// each is compared to a slot-based model and to an unstripper loopback.
module tb_byte_stripping;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] ds0 [2];
  logic [7:0] ds1 [2];
  logic       vs0 [2];
  logic       vs1 [2];
  logic       act [2];

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  byte_stripping #(.DATA_WIDTH(8), .IDLE_TIMEOUT(4)) dut (
    .clk_2f(clk), .reset(rst), .data_in(din), .valid_in(vin),
    .data_stripe_0(ds0[0]), .data_stripe_1(ds1[0]),
    .valid_stripe_0(vs0[0]), .valid_stripe_1(vs1[0]), .active(act[0])
  );

  byte_stripping #(.DATA_WIDTH(8), .IDLE_TIMEOUT(0)) dut_nt (
    .clk_2f(clk), .reset(rst), .data_in(din), .valid_in(vin),
    .data_stripe_0(ds0[1]), .data_stripe_1(ds1[1]),
    .valid_stripe_0(vs0[1]), .valid_stripe_1(vs1[1]), .active(act[1])
  );

  // Model: slot counter since burst start selects the lane; gap length ends bursts.
  int         to_lim [2] = '{4, 0};
  logic       m_burst [2];
  int         m_slot [2];
  int         m_gap [2];
  logic [7:0] m_d0 [2];
  logic [7:0] m_d1 [2];
  logic       m_v0 [2];
  logic       m_v1 [2];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic       lb_sel [2];
  logic       lb_prev [2];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_burst[k] = 1'b0; m_slot[k] = 0; m_gap[k] = 0;
        m_d0[k] = 8'h00; m_d1[k] = 8'h00; m_v0[k] = 1'b0; m_v1[k] = 1'b0;
      end else if (!m_burst[k]) begin
        m_v1[k] = 1'b0;
        m_v0[k] = vin;
        if (vin) begin
          m_d0[k] = din; m_burst[k] = 1'b1; m_slot[k] = 1; m_gap[k] = 0;
        end
      end else begin
        int lane;
        lane = m_slot[k] % 2;
        m_slot[k]++;
        if (vin) begin
          m_gap[k] = 0;
          if (lane == 0) begin m_d0[k] = din; m_v0[k] = 1'b1; end
          else           begin m_d1[k] = din; m_v1[k] = 1'b1; end
        end else begin
          m_gap[k]++;
          if (lane == 0) m_v0[k] = 1'b0;
          else           m_v1[k] = 1'b0;
          if (to_lim[k] > 0 && m_gap[k] == to_lim[k]) begin
            m_burst[k] = 1'b0; m_v0[k] = 1'b0; m_v1[k] = 1'b0; m_gap[k] = 0;
          end
        end
      end
    end
    if (vin && !rst) begin
      exp_q0.push_back(din);
      exp_q1.push_back(din);
    end
  end

  // Unstripper loopback: lane 0 on the first ACTIVE cycle, then alternate.
  task automatic loopback(input int k);
    logic [7:0] b;
    logic [7:0] e;
    if (act[k] === 1'b1) begin
      lb_sel[k] = lb_prev[k] ? ~lb_sel[k] : 1'b0;
      if ((lb_sel[k] ? vs1[k] : vs0[k]) === 1'b1) begin
        b = lb_sel[k] ? ds1[k] : ds0[k];
        if ((k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
          n_vec++; n_err++;
          $display("FAIL loopback%0d: got byte %0h expected none at %0t", k, b, $time);
        end else begin
          e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          cmp($sformatf("loopback%0d.byte", k), {24'h0, b}, {24'h0, e});
        end
      end
    end
    lb_prev[k] = (act[k] === 1'b1);
  endtask

  initial begin
    lb_prev = '{1'b0, 1'b0};
    lb_sel  = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          cmp($sformatf("dut%0d.data_stripe_0", k), {24'h0, ds0[k]}, {24'h0, m_d0[k]});
          cmp($sformatf("dut%0d.data_stripe_1", k), {24'h0, ds1[k]}, {24'h0, m_d1[k]});
          cmp($sformatf("dut%0d.valid_stripe_0", k), {31'h0, vs0[k]}, {31'h0, m_v0[k]});
          cmp($sformatf("dut%0d.valid_stripe_1", k), {31'h0, vs1[k]}, {31'h0, m_v1[k]});
          cmp($sformatf("dut%0d.active", k), {31'h0, act[k]}, {31'h0, m_burst[k]});
          loopback(k);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d);
    rst = 1'b0; vin = v; din = d;
    @(posedge clk); #1;
  endtask

  task automatic rcyc();
    rst = 1'b1; vin = 1'b1; din = 8'hFF;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic lanes(input string tag, input int k, input logic [7:0] d0, input logic v0,
                       input logic [7:0] d1, input logic v1, input logic a);
    cmp({tag, ".d0"}, {24'h0, ds0[k]}, {24'h0, d0});
    cmp({tag, ".v0"}, {31'h0, vs0[k]}, {31'h0, v0});
    cmp({tag, ".d1"}, {24'h0, ds1[k]}, {24'h0, d1});
    cmp({tag, ".v1"}, {31'h0, vs1[k]}, {31'h0, v1});
    cmp({tag, ".active"}, {31'h0, act[k]}, {31'h0, a});
  endtask

  initial begin
    // Reset held with valid data present
    rcyc(); rcyc(); rcyc();
    chk_en = 1'b1;
    lanes("reset", 0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    lanes("reset_nt", 1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back burst 01..06
    cyc(1'b1, 8'h01); lanes("b2b_01", 0, 8'h01, 1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h02); lanes("b2b_02", 0, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1);
    cyc(1'b1, 8'h03); lanes("b2b_03", 0, 8'h03, 1'b1, 8'h02, 1'b1, 1'b1);
    cyc(1'b1, 8'h04);
    cyc(1'b1, 8'h05);
    cyc(1'b1, 8'h06); lanes("b2b_06", 0, 8'h05, 1'b1, 8'h06, 1'b1, 1'b1);
    idle(1);          lanes("b2b_gap1", 0, 8'h05, 1'b0, 8'h06, 1'b1, 1'b1);
    idle(3);          lanes("b2b_end", 0, 8'h05, 1'b0, 8'h06, 1'b0, 1'b0);

    // Odd-length burst, active drops after exactly 4 idle cycles
    cyc(1'b1, 8'hA0); cyc(1'b1, 8'hA1); cyc(1'b1, 8'hA2);
    lanes("odd_A2", 0, 8'hA2, 1'b1, 8'hA1, 1'b1, 1'b1);
    idle(1); lanes("odd_i1", 0, 8'hA2, 1'b1, 8'hA1, 1'b0, 1'b1);
    idle(2); lanes("odd_i3", 0, 8'hA2, 1'b0, 8'hA1, 1'b0, 1'b1);
    idle(1); lanes("odd_i4", 0, 8'hA2, 1'b0, 8'hA1, 1'b0, 1'b0);

    // Short gap keeps phase; full timeout gap realigns
    cyc(1'b1, 8'h10); cyc(1'b1, 8'h11); idle(1); cyc(1'b1, 8'h12);
    lanes("gap1_12", 0, 8'h10, 1'b0, 8'h12, 1'b1, 1'b1);
    idle(4); cmp("gap4.active", {31'h0, act[0]}, 32'h0);
    cyc(1'b1, 8'h13);
    lanes("realign_13", 0, 8'h13, 1'b1, 8'h12, 1'b0, 1'b1);
    idle(4);

    // Reset mid-burst
    cyc(1'b1, 8'h20); cyc(1'b1, 8'h21);
    rcyc();           lanes("midrst", 0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h22); lanes("midrst_22", 0, 8'h22, 1'b1, 8'h00, 1'b0, 1'b1);
    idle(4);

    // No-timeout instance: phase keeps running through a long idle stretch
    rcyc();
    cyc(1'b1, 8'h30); cyc(1'b1, 8'h31); cyc(1'b1, 8'h32);
    idle(20);
    cmp("nt_idle20.active", {31'h0, act[1]}, 32'h1);
    cmp("to_idle20.active", {31'h0, act[0]}, 32'h0);
    cyc(1'b1, 8'h33);
    lanes("nt_33", 1, 8'h32, 1'b0, 8'h33, 1'b1, 1'b1);
    lanes("to_33", 0, 8'h33, 1'b1, 8'h31, 1'b0, 1'b1);
    idle(4);

    // Randomized bursts with gaps straddling the timeout and occasional resets
    for (int s = 0; s < 250; s++) begin
      int blen;
      int glen;
      if ($urandom_range(0, 39) == 0) rcyc();
      blen = $urandom_range(1, 9);
      for (int i = 0; i < blen; i++) begin
        cyc(1'b1, 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      glen = $urandom_range(0, 7);
      idle(glen);
    end
    idle(6);
    chk_en = 1'b0;

    cmp("loopback0.leftover", exp_q0.size(), 32'h0);
    cmp("loopback1.leftover", exp_q1.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
